// File: rtl/z_serial_cba_sub_pkg.sv
// Shared constants and FSM state type for the nibble-serial subtractor.
package z_serial_cba_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/z_serial_cba_sub_nibble_sub.sv
// Combinational 4-bit carry-bypass adder slice; b4 arrives already inverted for subtraction.
module z_nibble_sub
  import z_serial_cba_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s4,
  output logic                c_out
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic                c1, c2, c3, c4;

  assign p = a4 ^ b4;
  assign g = a4 & b4;

  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & c1);
  assign c3 = g[2] | (p[2] & c2);
  assign c4 = g[3] | (p[3] & c3);

  assign s4 = p ^ {c3, c2, c1, c_in};

  // When every bit propagates, the carry-in skips straight to the output.
  assign c_out = c4 | ((&p) & c_in);

endmodule

// File: rtl/z_serial_cba_sub.sv
// Nibble-serial subtractor: diff = a - b - b_in, one 4-bit carry-bypass slice per clock.
module z_serial_cba_sub
  import z_serial_cba_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               load;

  logic [NIBBLE_W-1:0] a4, b4, s4;
  logic                c_out;

  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a4 = a_q[n*NIBBLE_W +: NIBBLE_W];
        b4 = ~b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  z_nibble_sub u_nibble (
    .a4    (a4),
    .b4    (b4),
    .c_in  (carry_q),
    .s4    (s4),
    .c_out (c_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
          idx_d   = '0;
          carry_d = ~b_in;
          diff_d  = '0;
          bout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) diff_d[n*NIBBLE_W +: NIBBLE_W] = s4;
        end
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          // Final slice: the inverted carry is the borrow; s4[MSB] is the result sign.
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
          bout_d  = ~c_out;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (s4[NIBBLE_W-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Operand latches are only read in RUN, after a load, so they need no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = bout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_z_serial_cba_sub.sv
// Directed bench for the nibble-serial subtractor with hand-computed expected results.
module tb_z_serial_cba_sub;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             b_in;
  logic             ready, busy, done, b_out, ovf;
  logic [WIDTH-1:0] diff;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  z_serial_cba_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at 1 ns after a rising edge with ready high; returns 1 ns after the accepting edge.
  task automatic go(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic bi, input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    int n;
    go(av, bv, bi);
    chk({tag, "_busy"}, busy, 1'b1);
    wait_done(n);
    chk({tag, "_lat"}, n, NIBBLES);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, b_out, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_rdy"}, ready, 1'b1);
  endtask

  initial begin
    int n;
    int d0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_bout", b_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt, 0);

    run_op("t1", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_diff", diff, 16'h1200);
    chk("idle_done_low", done, 1'b0);

    run_op("t2_wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_op("t3_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    run_op("t3_bin", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_op("x_bin_neg", 16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op("x_ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Start pulse with new operands during RUN must be ignored.
    d0 = done_cnt;
    go(16'h1234, 16'h0034, 1'b0);
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h1111; b_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("t4_diff", diff, 16'h1200);
    chk("t4_bout", b_out, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_ready", ready, 1'b1);

    // Asynchronous abort in the second RUN cycle.
    d0 = done_cnt;
    go(16'h00FF, 16'h0011, 1'b0);
    @(posedge clk); #1;
    chk("t5_partial", diff, 16'h000E);
    rst_n = 1'b0;
    #1;
    chk("t5_ready", ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_diff", diff, 16'h0000);
    chk("t5_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle", ready, 1'b1);

    // Start held through the done cycle: back-to-back acceptance.
    d0 = done_cnt;
    a = 16'h1234; b = 16'h0034; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0000; b = 16'h0001;
    wait_done(n);
    chk("t6_first_lat", n, NIBBLES);
    chk("t6_first_diff", diff, 16'h1200);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_second_busy", busy, 1'b1);
    chk("t6_cleared", diff, 16'h0000);
    wait_done(n);
    chk("t6_second_lat", n, NIBBLES);
    chk("t6_second_diff", diff, 16'hFFFF);
    chk("t6_second_bout", b_out, 1'b1);
    @(posedge clk); #1;
    chk("t6_two_done", done_cnt - d0, 2);
    chk("t6_gap", last_done_cyc - prev_done_cyc, NIBBLES + 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
